irq_dispatcher: RTL and testbench

// Sequences delivery of interrupts from the event unit's interrupt service unit to the core.
// - Arbitrates round-robin among masked pending lines.
// - Presents one interrupt ID at a time to the core with a req/ack handshake.
// - Returns a one-hot clear pulse to the pending register.
// - Defers delivery for a programmable hold-off after the core leaves sleep.

---
 rtl/irq_dispatcher.sv | 108 ++++++++++
 tb/tb_irq_dispatcher.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/irq_dispatcher.sv
// Round-robin interrupt dispatcher: picks one masked pending line, offers its ID to the
// core over req/ack, then pulses a one-hot clear back to the pending register.
module irq_dispatcher #(
  parameter int NUM_IRQ      = 32,
  parameter int ID_WIDTH     = 5,
  parameter int WAKE_HOLDOFF = 4
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [NUM_IRQ-1:0]  irq_pending_i,
  input  logic [NUM_IRQ-1:0]  irq_mask_i,
  input  logic                core_sleeping_i,
  output logic                irq_req_o,
  output logic [ID_WIDTH-1:0] irq_id_o,
  input  logic                irq_ack_i,
  output logic [NUM_IRQ-1:0]  irq_clear_o,
  output logic                busy_o
);

  localparam int SW = ID_WIDTH + 1;
  localparam int HW = (WAKE_HOLDOFF > 0) ? $clog2(WAKE_HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] rr_ptr, rr_nxt;
  logic [HW-1:0]       holdoff_cnt;
  logic                req_nxt, busy_nxt;
  logic [ID_WIDTH-1:0] id_nxt;
  logic [NUM_IRQ-1:0]  clr_nxt;

  logic [NUM_IRQ-1:0]  eligible, rotated, cur_onehot;
  logic [ID_WIDTH-1:0] win_ofs, win_id;
  logic [SW-1:0]       win_sum;
  logic                arb_ok;

  assign eligible   = irq_pending_i & irq_mask_i;
  assign arb_ok     = !core_sleeping_i && (holdoff_cnt == '0);
  assign cur_onehot = NUM_IRQ'(1) << irq_id_o;

  // Rotate so rr_ptr lands at bit 0; the lowest set bit is then the next line in RR order.
  always_comb begin
    rotated = NUM_IRQ'({eligible, eligible} >> rr_ptr);
    win_ofs = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (rotated[i]) win_ofs = ID_WIDTH'(i);
    win_sum = SW'(rr_ptr) + SW'(win_ofs);
    if (win_sum >= SW'(NUM_IRQ)) win_sum = win_sum - SW'(NUM_IRQ);
    win_id = win_sum[ID_WIDTH-1:0];
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = irq_req_o;
    id_nxt    = irq_id_o;
    clr_nxt   = '0;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (arb_ok && |eligible) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          id_nxt    = win_id;
        end
      end
      REQ: begin
        // Ack takes priority over a same-cycle withdrawal; sleep does not cancel a request.
        if (irq_ack_i) begin
          state_nxt = CLEAR;
          req_nxt   = 1'b0;
          clr_nxt   = cur_onehot;
          rr_nxt    = (irq_id_o == ID_WIDTH'(NUM_IRQ - 1)) ? '0 : irq_id_o + 1'b1;
        end else if (!(|(eligible & cur_onehot))) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      CLEAR: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= IDLE;
      irq_req_o   <= 1'b0;
      irq_id_o    <= '0;
      irq_clear_o <= '0;
      busy_o      <= 1'b0;
      rr_ptr      <= '0;
      holdoff_cnt <= '0;
    end else begin
      state       <= state_nxt;
      irq_req_o   <= req_nxt;
      irq_id_o    <= id_nxt;
      irq_clear_o <= clr_nxt;
      busy_o      <= busy_nxt;
      rr_ptr      <= rr_nxt;
      if (core_sleeping_i)          holdoff_cnt <= HW'(WAKE_HOLDOFF);
      else if (holdoff_cnt != '0)   holdoff_cnt <= holdoff_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_irq_dispatcher.sv
// Directed bench for irq_dispatcher: reset, round robin, wake hold-off, withdrawal,
// back-to-back grants and reset during an outstanding request.
module tb_irq_dispatcher;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] irq_pending_i, irq_mask_i;
  logic        core_sleeping_i, irq_ack_i;
  logic        irq_req_o, busy_o;
  logic [4:0]  irq_id_o;
  logic [31:0] irq_clear_o;

  int errors = 0;
  int checks = 0;

  irq_dispatcher #(.NUM_IRQ(32), .ID_WIDTH(5), .WAKE_HOLDOFF(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .irq_pending_i(irq_pending_i), .irq_mask_i(irq_mask_i),
    .core_sleeping_i(core_sleeping_i),
    .irq_req_o(irq_req_o), .irq_id_o(irq_id_o), .irq_ack_i(irq_ack_i),
    .irq_clear_o(irq_clear_o), .busy_o(busy_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs and samples both happen 1 time unit after the rising edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!irq_req_o && n < 50) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, irq_req_o}, 32'd1);
  endtask

  task automatic do_reset();
    HRESET = 1'b1; irq_pending_i = '0; irq_mask_i = '0;
    irq_ack_i = 1'b0; core_sleeping_i = 1'b0;
    tick(); tick();
    HRESET = 1'b0;
  endtask

  logic [4:0]  t2_id  [4] = '{5'd0, 5'd4, 5'd8, 5'd0};
  logic [31:0] t2_clr [4] = '{32'h1, 32'h10, 32'h100, 32'h1};

  initial begin
    // T1: reset with everything pending
    HRESET = 1'b1; irq_pending_i = 32'hFFFF_FFFF; irq_mask_i = 32'hFFFF_FFFF;
    core_sleeping_i = 1'b0; irq_ack_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("t1_rst_req",   {31'd0, irq_req_o}, 32'd0);
      chk("t1_rst_clear", irq_clear_o,        32'd0);
      chk("t1_rst_busy",  {31'd0, busy_o},    32'd0);
    end
    HRESET = 1'b0;
    tick();
    chk("t1_req", {31'd0, irq_req_o}, 32'd1);
    chk("t1_id",  {27'd0, irq_id_o},  32'd0);

    // T2: round robin over lines 0,4,8; bit 0 re-pends once all are drained
    do_reset();
    irq_pending_i = 32'h111; irq_mask_i = 32'h111;
    for (int k = 0; k < 4; k++) begin
      wait_req("t2_req_seen");
      chk("t2_id", {27'd0, irq_id_o}, {27'd0, t2_id[k]});
      tick();
      chk("t2_req_held", {31'd0, irq_req_o}, 32'd1);
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      chk("t2_clear",     irq_clear_o,        t2_clr[k]);
      chk("t2_req_drop",  {31'd0, irq_req_o}, 32'd0);
      irq_pending_i = irq_pending_i & ~t2_clr[k];
      if (irq_pending_i == 32'd0) irq_pending_i = 32'h111;
    end

    // T3: wake hold-off of 4 cycles
    do_reset();
    irq_pending_i = 32'h8; irq_mask_i = 32'h8; core_sleeping_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_sleep_req", {31'd0, irq_req_o}, 32'd0);
    end
    core_sleeping_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t3_holdoff_req", {31'd0, irq_req_o}, 32'd0);
    end
    tick();
    chk("t3_req", {31'd0, irq_req_o}, 32'd1);
    chk("t3_id",  {27'd0, irq_id_o},  32'd3);

    // T4: withdrawal by mask, then ack and mask drop in the same cycle
    do_reset();
    irq_pending_i = 32'h20; irq_mask_i = 32'h20;
    tick();
    chk("t4_req", {31'd0, irq_req_o}, 32'd1);
    chk("t4_id",  {27'd0, irq_id_o},  32'd5);
    chk("t4_busy", {31'd0, busy_o},   32'd1);
    irq_mask_i = 32'h0;
    tick();
    chk("t4_wd_req",   {31'd0, irq_req_o}, 32'd0);
    chk("t4_wd_clear", irq_clear_o,        32'd0);
    chk("t4_wd_busy",  {31'd0, busy_o},    32'd0);
    irq_pending_i = 32'h41; irq_mask_i = 32'h41;
    tick();
    chk("t4_ptr_kept_id", {27'd0, irq_id_o}, 32'd0);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    chk("t4_clear0", irq_clear_o, 32'h1);
    irq_pending_i = 32'h20; irq_mask_i = 32'h20;
    wait_req("t4_req2_seen");
    chk("t4_id2", {27'd0, irq_id_o}, 32'd5);
    irq_ack_i = 1'b1; irq_mask_i = 32'h0;
    tick();
    irq_ack_i = 1'b0;
    chk("t4_ackwd_clear", irq_clear_o,        32'h20);
    chk("t4_ackwd_req",   {31'd0, irq_req_o}, 32'd0);

    // T5: back-to-back with ack held high, 33 grants to see the wrap
    do_reset();
    irq_pending_i = 32'hFFFF_FFFF; irq_mask_i = 32'hFFFF_FFFF; irq_ack_i = 1'b1;
    for (int g = 0; g < 33; g++) begin
      tick();
      chk("t5_req1", {31'd0, irq_req_o}, 32'd1);
      chk("t5_id",   {27'd0, irq_id_o},  32'(g % 32));
      tick();
      chk("t5_req0a", {31'd0, irq_req_o}, 32'd0);
      chk("t5_clear", irq_clear_o,        32'd1 << (g % 32));
      tick();
      chk("t5_req0b", {31'd0, irq_req_o}, 32'd0);
      chk("t5_noclr", irq_clear_o,        32'd0);
    end
    irq_ack_i = 1'b0; irq_pending_i = '0;

    // T6: reset while id 7 is requested, pointer previously advanced to 5
    do_reset();
    irq_pending_i = 32'h10; irq_mask_i = 32'h10;
    wait_req("t6_req4_seen");
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    irq_pending_i = 32'h80; irq_mask_i = 32'h80;
    wait_req("t6_req7_seen");
    chk("t6_id7", {27'd0, irq_id_o}, 32'd7);
    HRESET = 1'b1;
    tick();
    chk("t6_rst_req",   {31'd0, irq_req_o}, 32'd0);
    chk("t6_rst_clear", irq_clear_o,        32'd0);
    chk("t6_rst_busy",  {31'd0, busy_o},    32'd0);
    tick();
    chk("t6_rst_clear2", irq_clear_o, 32'd0);
    HRESET = 1'b0;
    irq_pending_i = 32'h81; irq_mask_i = 32'h81;
    tick();
    chk("t6_rearb_req", {31'd0, irq_req_o}, 32'd1);
    chk("t6_rearb_id",  {27'd0, irq_id_o},  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
